mod_demodulator: RTL and testbench
==================================

# mod_demodulator

Coherent ASK/BPSK demodulator for the lab 5 signal path. Consumes the same 12-bit modulated stream the scope selector routes to `mod_out`, together with the DDS sine reference and the LFSR symbol timing, and recovers one data bit per symbol. Recovered bits are checked against the transmitted LFSR bit so the board can report bit-error counts. It is the receive end of the ASK/BPSK modulator chain.

## Interface
- `MAX_SAMPLES`, 4096, maximum clocks per symbol before overrun
- `ACC_W`, 40, accumulator width (≥ 24 + clog2(MAX_SAMPLES))
- `clk` in 1: single system clock
- `rst_n` in 1: reset, asynchronous and active-low
- `mod_sel` in 4: 4'd0 = ASK, 4'd2 = BPSK, any other value = disabled
- `mod_in` in 12: modulated sample, two's complement
- `sin_ref` in 12: carrier reference, two's complement, phase-aligned with `mod_in`
- `sym_strobe` in 1: one-cycle pulse on the first sample of each symbol
- `lfsr_ref` in 1: transmitted bit, stable for the whole symbol
- `clr_cnt` in 1: synchronous clear of the counters
- `bit_out` out 1: last recovered bit
- `bit_valid` out 1: one-cycle pulse, `bit_out` updated
- `bit_err` out 1: qualifies `bit_valid`; recovered bit differs from the reference
- `overrun` out 1: one-cycle pulse, symbol exceeded `MAX_SAMPLES`
- `bit_cnt` out 16: symbols decided, saturating
- `err_cnt` out 16: mismatches, saturating

## Operation
- FSM states are IDLE, SYNC and INTEG.
- IDLE: entered when `mod_sel` is unsupported. Accumulators are held at zero. Leaves to SYNC when `mod_sel` becomes 0 or 2.
- SYNC: waits for `sym_strobe`, so any partial symbol is discarded. On the strobe it goes to INTEG and that cycle's sample is accumulated as sample 0. `lfsr_ref` is captured into `ref_bit`.
- INTEG: every cycle adds to the accumulators.
  - ASK: `acc_a += |mod_in|`, `acc_b += |sin_ref|`. |−2048| is taken as 2048, unsigned 13-bit.
  - BPSK: `acc_a += mod_in * sin_ref`, a signed 24-bit product sign-extended to ACC_W. `acc_b` is unused.
  - The sample counter increments on each accumulated sample.
- Decision on `sym_strobe` while in INTEG. The decision uses the accumulators before the current sample.
  - ASK: bit = (2·acc_a > acc_b).
  - BPSK: bit = (acc_a ≥ 0).
  - Then: `bit_out` ← bit, `bit_err` ← bit ^ `ref_bit`, `bit_cnt` increments, `err_cnt` increments if there is an error, both saturating at 16'hFFFF.
  - Accumulators are reloaded with the current sample's term, the counter is set to 1, and `ref_bit` ← `lfsr_ref`.
- Overrun: if the counter reaches `MAX_SAMPLES` with no strobe, pulse `overrun`, clear the accumulators and go to SYNC. No decision is made.
- `mod_sel` change while in SYNC or INTEG:
  - to another supported value: go to SYNC, no decision.
  - to an unsupported value: go to IDLE.
- `clr_cnt` zeroes `bit_cnt` and `err_cnt`. It takes priority over an increment in the same cycle. The FSM is unaffected.

## Timing
- Reset values: state IDLE, accumulators 0, `bit_out` 0, `bit_valid` 0, `bit_err` 0, `overrun` 0, `bit_cnt` 0, `err_cnt` 0.
- `rst_n` asserted mid-symbol clears everything immediately, asynchronously. After release the block restarts from IDLE and the first symbol seen is discarded in SYNC.
- Latency: `bit_valid`, `bit_out` and `bit_err` are registered and appear the cycle after the closing `sym_strobe`. The counters update in that same cycle.
- `bit_valid` is high for exactly one cycle per decided symbol. `bit_out` holds until the next decision.
- Back-to-back strobes (a 1-sample symbol) are legal. The decision is based on a single sample.
- A strobe in the same cycle as counter = `MAX_SAMPLES`: the decision wins, no overrun.
- There is no input handshake. Every cycle is one sample.

## Structure
- Shared package `lab5_pkg` holds:
  - `mod_sel` encodings (`MOD_ASK` = 4'd0, `MOD_BPSK` = 4'd2)
  - the `demod_state_t` enum
  - `SAMPLE_W` = 12
- Sub-module `demod_accum` contains the per-sample term generation (abs or multiply), the accumulators and the sample counter. The top level keeps the FSM, the decision logic and the counters.

## Test plan
- **BPSK clean:** `mod_sel`=2, `sin_ref` = 16-sample sine of amplitude 1000, `mod_in` = ±`sin_ref` following `lfsr_ref` pattern 1,0,1,1, strobe every 16 cycles. Expect the first symbol discarded, then `bit_out` 1,0,1,1 with `bit_err`=0 and `bit_cnt`=4.
- **ASK clean:** `mod_sel`=0, `mod_in` = `sin_ref` for bit 1 and 0 for bit 0, pattern 0,1,1,0. Expect the same bits and `err_cnt`=0.
- **Forced errors:** in BPSK, invert `mod_in` on 2 of 8 symbols. Expect `bit_err` pulses on exactly those symbols and `err_cnt`=2. Then `clr_cnt` returns both counters to 0.
- **Overrun:** `mod_sel`=2 with no strobe for `MAX_SAMPLES` cycles after sync. Expect one `overrun` pulse, no `bit_valid`, state SYNC.
- **Mode change and reset:** switch `mod_sel` 2→0 mid-symbol. Expect no decision for that symbol and the next one discarded. Switch to 3: expect IDLE and no `bit_valid`. Assert `rst_n` mid-symbol: all outputs go to 0 immediately.
- **Saturation and boundaries:** preload `bit_cnt` near 16'hFFFF via a long run. Expect it to hold at FFFF. Test back-to-back strobes, and inputs of −2048 in ASK treated as magnitude 2048.

Source files
------------

// File: rtl/lab5_pkg.sv
// Shared definitions for the lab 5 signal path: modulation select codes,
// sample width and the demodulator state encoding.
package lab5_pkg;

  localparam int SAMPLE_W = 12;

  localparam logic [3:0] MOD_ASK  = 4'd0;
  localparam logic [3:0] MOD_BPSK = 4'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    INTEG = 2'd2
  } demod_state_t;

endpackage

// File: rtl/demod_accum.sv
// Per-sample term generation (magnitude for ASK, product for BPSK), the two
// symbol accumulators and the sample counter.
module demod_accum
  import lab5_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 13
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ask_mode,
  input  logic                       clear,
  input  logic                       load,
  input  logic                       add,
  input  logic signed [SAMPLE_W-1:0] mod_in,
  input  logic signed [SAMPLE_W-1:0] sin_ref,
  output logic signed [ACC_W-1:0]    acc_a,
  output logic signed [ACC_W-1:0]    acc_b,
  output logic [CNT_W-1:0]           cnt
);

  logic [SAMPLE_W:0]             abs_mod;
  logic [SAMPLE_W:0]             abs_sin;
  logic signed [2*SAMPLE_W-1:0]  prod;
  logic signed [ACC_W-1:0]       term_a;
  logic signed [ACC_W-1:0]       term_b;

  // Magnitudes are one bit wider so that -2048 maps to +2048.
  always_comb begin
    abs_mod = mod_in[SAMPLE_W-1] ? (~{mod_in[SAMPLE_W-1], mod_in}) + (SAMPLE_W+1)'(1)
                                 : {1'b0, mod_in};
    abs_sin = sin_ref[SAMPLE_W-1] ? (~{sin_ref[SAMPLE_W-1], sin_ref}) + (SAMPLE_W+1)'(1)
                                  : {1'b0, sin_ref};
    prod    = mod_in * sin_ref;
    if (ask_mode) begin
      term_a = {{(ACC_W-SAMPLE_W-1){1'b0}}, abs_mod};
      term_b = {{(ACC_W-SAMPLE_W-1){1'b0}}, abs_sin};
    end else begin
      term_a = {{(ACC_W-2*SAMPLE_W){prod[2*SAMPLE_W-1]}}, prod};
      term_b = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a <= '0;
      acc_b <= '0;
      cnt   <= '0;
    end else if (clear) begin
      acc_a <= '0;
      acc_b <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc_a <= term_a;
      acc_b <= term_b;
      cnt   <= CNT_W'(1);
    end else if (add) begin
      acc_a <= acc_a + term_a;
      acc_b <= acc_b + term_b;
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mod_demodulator.sv
// Coherent ASK/BPSK demodulator: symbol-synchronous integrate-and-decide with
// bit/error counters against the transmitted LFSR bit.
//
// state | meaning
// IDLE  | mod_sel unsupported, accumulators held at zero
// SYNC  | waiting for sym_strobe, partial symbol discarded
// INTEG | accumulating samples, decide on the next strobe
module mod_demodulator
  import lab5_pkg::*;
#(
  parameter int MAX_SAMPLES = 4096,
  parameter int ACC_W       = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          mod_sel,
  input  logic [SAMPLE_W-1:0] mod_in,
  input  logic [SAMPLE_W-1:0] sin_ref,
  input  logic                sym_strobe,
  input  logic                lfsr_ref,
  input  logic                clr_cnt,
  output logic                bit_out,
  output logic                bit_valid,
  output logic                bit_err,
  output logic                overrun,
  output logic [15:0]         bit_cnt,
  output logic [15:0]         err_cnt
);

  localparam int CNT_W = $clog2(MAX_SAMPLES + 1);

  demod_state_t            state, state_nxt;
  logic [3:0]              sel_q;
  logic                    ref_bit;
  logic                    sel_ok, sel_chg, ask_mode;
  logic                    acc_clear, acc_load, acc_add, decide, ovr;
  logic signed [ACC_W-1:0] acc_a, acc_b;
  logic [CNT_W-1:0]        cnt;
  logic [ACC_W:0]          ask_lhs, ask_rhs;
  logic                    dec_bit;

  assign sel_ok   = (mod_sel == MOD_ASK) || (mod_sel == MOD_BPSK);
  assign sel_chg  = (mod_sel != sel_q);
  assign ask_mode = (mod_sel == MOD_ASK);

  demod_accum #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .ask_mode (ask_mode),
    .clear    (acc_clear),
    .load     (acc_load),
    .add      (acc_add),
    .mod_in   (mod_in),
    .sin_ref  (sin_ref),
    .acc_a    (acc_a),
    .acc_b    (acc_b),
    .cnt      (cnt)
  );

  // ASK accumulators are never negative, so an unsigned compare is exact.
  assign ask_lhs = {acc_a, 1'b0};
  assign ask_rhs = {1'b0, acc_b};
  assign dec_bit = ask_mode ? (ask_lhs > ask_rhs) : ~acc_a[ACC_W-1];

  always_comb begin
    state_nxt = state;
    acc_clear = 1'b0;
    acc_load  = 1'b0;
    acc_add   = 1'b0;
    decide    = 1'b0;
    ovr       = 1'b0;
    case (state)
      IDLE: begin
        acc_clear = 1'b1;
        if (sel_ok) state_nxt = SYNC;
      end
      SYNC: begin
        if (!sel_ok) begin
          state_nxt = IDLE;
          acc_clear = 1'b1;
        end else if (sym_strobe) begin
          state_nxt = INTEG;
          acc_load  = 1'b1;
        end else begin
          acc_clear = 1'b1;
        end
      end
      INTEG: begin
        if (!sel_ok) begin
          state_nxt = IDLE;
          acc_clear = 1'b1;
        end else if (sel_chg) begin
          state_nxt = SYNC;
          acc_clear = 1'b1;
        end else if (sym_strobe) begin
          decide   = 1'b1;
          acc_load = 1'b1;
        end else if (cnt == CNT_W'(MAX_SAMPLES)) begin
          ovr       = 1'b1;
          acc_clear = 1'b1;
          state_nxt = SYNC;
        end else begin
          acc_add = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        acc_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= '0;
      ref_bit   <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_err   <= 1'b0;
      overrun   <= 1'b0;
      bit_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      sel_q     <= mod_sel;
      bit_valid <= decide;
      overrun   <= ovr;
      if (acc_load) ref_bit <= lfsr_ref;
      if (decide) begin
        bit_out <= dec_bit;
        bit_err <= dec_bit ^ ref_bit;
      end
      if (clr_cnt) begin
        bit_cnt <= '0;
        err_cnt <= '0;
      end else if (decide) begin
        if (bit_cnt != 16'hFFFF) bit_cnt <= bit_cnt + 16'd1;
        if ((dec_bit ^ ref_bit) && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mod_demodulator.sv
// Scoreboard bench for mod_demodulator: a symbol-level reference model pushes
// expected decisions/overruns, a negedge monitor pops and compares them.
module tb_mod_demodulator;

  localparam int MAX_S = 256;
  localparam int ACC_W = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mod_sel;
  logic [11:0] mod_in;
  logic [11:0] sin_ref;
  logic        sym_strobe;
  logic        lfsr_ref;
  logic        clr_cnt;
  logic        bit_out, bit_valid, bit_err, overrun;
  logic [15:0] bit_cnt, err_cnt;

  mod_demodulator #(.MAX_SAMPLES(MAX_S), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mod_sel    (mod_sel),
    .mod_in     (mod_in),
    .sin_ref    (sin_ref),
    .sym_strobe (sym_strobe),
    .lfsr_ref   (lfsr_ref),
    .clr_cnt    (clr_cnt),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bit_err    (bit_err),
    .overrun    (overrun),
    .bit_cnt    (bit_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ovr;
    bit b;
    bit e;
    int bc;
    int ec;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   bv_seen = 0;
  int   ov_seen = 0;

  int sine[16] = '{0, 383, 707, 924, 1000, 924, 707, 383,
                   0, -383, -707, -924, -1000, -924, -707, -383};

  // Reference model: the current symbol is simply a list of samples.
  int m_phase;     // 0 = not running, 1 = waiting for a strobe, 2 = collecting
  int m_prev_sel;
  int m_bc, m_ec;
  bit m_ref;
  int sm[$];
  int ss[$];

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_prev_sel = 0;
    m_bc = 0;
    m_ec = 0;
    m_ref = 1'b0;
    sm.delete();
    ss.delete();
    exp_q.delete();
  endfunction

  function automatic void start_sym();
    sm.delete();
    ss.delete();
    sm.push_back(int'($signed(mod_in)));
    ss.push_back(int'($signed(sin_ref)));
    m_ref = lfsr_ref;
  endfunction

  function automatic bit decide_bit(bit ask);
    longint s1 = 0;
    longint s2 = 0;
    foreach (sm[i]) begin
      if (ask) begin
        s1 += (sm[i] < 0) ? -sm[i] : sm[i];
        s2 += (ss[i] < 0) ? -ss[i] : ss[i];
      end else begin
        s1 += longint'(sm[i]) * longint'(ss[i]);
      end
    end
    return ask ? (2 * s1 > s2) : (s1 >= 0);
  endfunction

  function automatic void step();
    int   sel = int'(mod_sel);
    bit   sup = (sel == 0) || (sel == 2);
    bit   dec = 1'b0;
    bit   ovr = 1'b0;
    bit   b = 1'b0;
    bit   er = 1'b0;
    exp_t e;
    if (m_phase == 0) begin
      if (sup) m_phase = 1;
    end else if (!sup) begin
      m_phase = 0;
    end else if (m_phase == 2 && sel != m_prev_sel) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (sym_strobe) begin
        m_phase = 2;
        start_sym();
      end
    end else if (sym_strobe) begin
      b   = decide_bit(sel == 0);
      er  = b ^ m_ref;
      dec = 1'b1;
      start_sym();
    end else if (sm.size() == MAX_S) begin
      ovr = 1'b1;
      m_phase = 1;
    end else begin
      sm.push_back(int'($signed(mod_in)));
      ss.push_back(int'($signed(sin_ref)));
    end
    if (dec) begin
      if (m_bc < 65535) m_bc++;
      if (er && m_ec < 65535) m_ec++;
    end
    if (clr_cnt) begin
      m_bc = 0;
      m_ec = 0;
    end
    if (dec) begin
      e.ovr = 1'b0; e.b = b; e.e = er; e.bc = m_bc; e.ec = m_ec;
      exp_q.push_back(e);
    end
    if (ovr) begin
      e.ovr = 1'b1; e.b = 1'b0; e.e = 1'b0; e.bc = 0; e.ec = 0;
      exp_q.push_back(e);
    end
    m_prev_sel = sel;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (bit_valid || overrun)) begin
      if (bit_valid) bv_seen++;
      if (overrun) ov_seen++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: bit_valid=%0b overrun=%0b, expected no output (t=%0t)",
                 bit_valid, overrun, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("overrun_pulse", overrun, mon_e.ovr);
        chk("bit_valid_pulse", bit_valid, !mon_e.ovr);
        if (!mon_e.ovr) begin
          chk("bit_out", bit_out, mon_e.b);
          chk("bit_err", bit_err, mon_e.e);
          chk("bit_cnt", bit_cnt, mon_e.bc);
          chk("err_cnt", err_cnt, mon_e.ec);
        end
      end
    end
  end

  task automatic cyc(int sel, int m, int s, bit stb, bit lf, bit clr = 1'b0);
    @(negedge clk);
    mod_sel    = sel[3:0];
    mod_in     = m[11:0];
    sin_ref    = s[11:0];
    sym_strobe = stb;
    lfsr_ref   = lf;
    clr_cnt    = clr;
    step();
  endtask

  task automatic send_sym(int sel, int len, bit b, bit flip = 1'b0);
    for (int k = 0; k < len; k++) begin
      int s = sine[k % 16];
      int m;
      if (sel == 2) m = (b ^ flip) ? s : -s;
      else          m = (b ^ flip) ? s : 0;
      cyc(sel, m, s, k == 0, b);
    end
  endtask

  task automatic drain();
    repeat (3) cyc(3, 0, 0, 1'b0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bit_out", bit_out, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_bit_err", bit_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_sym();
    int  r    = $urandom_range(0, 19);
    int  sel  = (r < 9) ? 0 : (r < 18) ? 2 : (r == 18) ? 3 : 7;
    int  len  = $urandom_range(1, 20);
    bit  b    = 1'($urandom_range(0, 1));
    bit  clr  = ($urandom_range(0, 15) == 0);
    int  kind = $urandom_range(0, 2);
    for (int k = 0; k < len; k++) begin
      int s, m;
      if (kind == 0) begin
        s = sine[k % 16];
        m = (sel == 2) ? (b ? s : -s) : (b ? s : 0);
        m += int'($urandom_range(0, 400)) - 200;
        if (m > 2047) m = 2047;
        if (m < -2048) m = -2048;
      end else begin
        s = int'($urandom_range(0, 4095)) - 2048;
        m = int'($urandom_range(0, 4095)) - 2048;
      end
      cyc(sel, m, s, k == 0, b, clr && (k == len - 1));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ov0, bv0;
    rst_n = 1'b0;
    mod_sel = 4'd3; mod_in = '0; sin_ref = '0;
    sym_strobe = 1'b0; lfsr_ref = 1'b0; clr_cnt = 1'b0;
    model_reset();
    #3;
    chk("reset_bit_out", bit_out, 0);
    chk("reset_bit_valid", bit_valid, 0);
    chk("reset_bit_err", bit_err, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_bit_cnt", bit_cnt, 0);
    chk("reset_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // BPSK clean: first symbol lost while leaving IDLE, then 1,0,1,1.
    send_sym(2, 16, 1'b0);
    send_sym(2, 16, 1'b1);
    send_sym(2, 16, 1'b0);
    send_sym(2, 16, 1'b1);
    send_sym(2, 16, 1'b1);
    send_sym(2, 16, 1'b0);
    drain();
    chk("bpsk_clean_bit_cnt", bit_cnt, 4);
    chk("bpsk_clean_err_cnt", err_cnt, 0);

    // ASK clean, pattern 0,1,1,0.
    send_sym(0, 16, 1'b1);
    send_sym(0, 16, 1'b0);
    send_sym(0, 16, 1'b1);
    send_sym(0, 16, 1'b1);
    send_sym(0, 16, 1'b0);
    send_sym(0, 16, 1'b1);
    drain();
    chk("ask_clean_bit_cnt", bit_cnt, 8);
    chk("ask_clean_err_cnt", err_cnt, 0);

    // Forced errors on two of eight BPSK symbols, then clear.
    cyc(3, 0, 0, 1'b0, 1'b0, 1'b1);
    send_sym(2, 16, 1'b0);
    for (int i = 0; i < 8; i++) send_sym(2, 16, 1'(i % 3 == 0), (i == 2) || (i == 5));
    send_sym(2, 16, 1'b0);
    drain();
    chk("forced_err_cnt", err_cnt, 2);
    chk("forced_bit_cnt", bit_cnt, 8);
    cyc(3, 0, 0, 1'b0, 1'b0, 1'b1);
    cyc(3, 0, 0, 1'b0, 1'b0);
    chk("clr_bit_cnt", bit_cnt, 0);
    chk("clr_err_cnt", err_cnt, 0);
    model_reset();
    exp_q.delete();

    // Overrun, then a symbol of exactly MAX_S samples (decision wins).
    ov0 = ov_seen;
    bv0 = bv_seen;
    cyc(2, 0, 0, 1'b0, 1'b0);
    cyc(2, 500, 500, 1'b1, 1'b1);
    repeat (MAX_S + 4) cyc(2, 500, 500, 1'b0, 1'b1);
    chk("overrun_count", ov_seen - ov0, 1);
    chk("overrun_no_valid", bv_seen - bv0, 0);
    send_sym(2, MAX_S, 1'b1);
    send_sym(2, 4, 1'b0);
    drain();
    chk("boundary_overrun_count", ov_seen - ov0, 1);
    chk("boundary_valid_count", bv_seen - bv0, 1);

    // Mode change mid-symbol, then unsupported mode.
    send_sym(2, 16, 1'b1);
    send_sym(2, 16, 1'b0);
    send_sym(2, 8, 1'b1);
    for (int k = 8; k < 16; k++) cyc(0, sine[k], sine[k], 1'b0, 1'b1);
    send_sym(0, 16, 1'b1);
    send_sym(0, 16, 1'b0);
    send_sym(0, 8, 1'b1);
    bv0 = bv_seen;
    repeat (20) cyc(3, 700, 700, 1'b1, 1'b1);
    chk("idle_no_valid", bv_seen - bv0, 0);

    // Reset mid-symbol after a recent decision.
    send_sym(2, 8, 1'b1);
    send_sym(2, 8, 1'b1);
    send_sym(2, 8, 1'b1);
    send_sym(2, 3, 1'b1);
    reset_mid();

    // ASK -2048 magnitudes with back-to-back strobes.
    cyc(0, 0, 0, 1'b0, 1'b0);
    cyc(0, -2048, 2047, 1'b1, 1'b1);
    cyc(0, -2048, 2047, 1'b1, 1'b1);
    cyc(0, 1024, -2048, 1'b1, 1'b0);
    cyc(0, 1025, -2048, 1'b1, 1'b1);
    cyc(0, 0, 0, 1'b1, 1'b0);
    drain();

    // Randomized symbols in ASK, BPSK and unsupported modes.
    for (int i = 0; i < 300; i++) rand_sym();
    drain();

    // Saturation of bit_cnt with one-sample symbols.
    cyc(3, 0, 0, 1'b0, 1'b0, 1'b1);
    cyc(2, 0, 0, 1'b0, 1'b0);
    repeat (65540) cyc(2, 100, 100, 1'b1, 1'b1);
    drain();
    chk("sat_bit_cnt", bit_cnt, 16'hFFFF);
    chk("sat_err_cnt", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
